// File: rtl/paint_arbiter_rr.sv
// rtl/paint_arbiter_rr.sv - round-robin owner arbitration of a shared registered pixel plot bus
module paint_arbiter_rr #(
    parameter int NUM_SRC     = 8,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int C_W         = 3,
    parameter int SLOT_CYCLES = 128
) (
    input  logic                         CLOCK_50,
    input  logic                         rstn,
    input  logic [NUM_SRC-1:0]           src_req,
    input  logic [NUM_SRC-1:0]           src_mask,
    input  logic [NUM_SRC-1:0]           src_plot_en,
    input  logic [NUM_SRC*X_W-1:0]       src_x,
    input  logic [NUM_SRC*Y_W-1:0]       src_y,
    input  logic [NUM_SRC*C_W-1:0]       src_color,
    output logic [NUM_SRC-1:0]           src_gnt,
    output logic [$clog2(NUM_SRC)-1:0]   grant_id,
    output logic                         busy,
    output logic [X_W-1:0]               VGA_X,
    output logic [Y_W-1:0]               VGA_Y,
    output logic [C_W-1:0]               VGA_COLOR,
    output logic                         plot_enable
);
    localparam int ID_W  = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state, state_nx;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nx, grant_id_nx;
    logic [CNT_W-1:0]   slot_cnt, slot_cnt_nx;
    logic [NUM_SRC-1:0] elig;

    logic               owner_elig, owner_plot_en, accept;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [C_W-1:0]     sel_c;

    logic               hi_found, lo_found, found;
    logic [ID_W-1:0]    hi_pick, lo_pick, pick;

    assign elig = src_req & ~src_mask;
    assign busy = (state == GRANT);

    // Constant-index mux of the current owner's lane
    always_comb begin
        owner_elig    = 1'b0;
        owner_plot_en = 1'b0;
        sel_x         = '0;
        sel_y         = '0;
        sel_c         = '0;
        src_gnt       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_elig    = elig[i];
                owner_plot_en = src_plot_en[i];
                sel_x         = src_x[i*X_W +: X_W];
                sel_y         = src_y[i*Y_W +: Y_W];
                sel_c         = src_color[i*C_W +: C_W];
                src_gnt[i]    = (state == GRANT);
            end
        end
    end

    assign accept = (state == GRANT) && owner_elig && owner_plot_en;

    // Lowest eligible index at or above rr_ptr, else lowest eligible overall (wrap)
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_found = 1'b1;
                lo_pick  = ID_W'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_pick  = ID_W'(i);
                end
            end
        end
        found = hi_found || lo_found;
        pick  = hi_found ? hi_pick : lo_pick;
    end

    always_comb begin
        state_nx    = state;
        grant_id_nx = grant_id;
        rr_ptr_nx   = rr_ptr;
        slot_cnt_nx = slot_cnt;
        case (state)
            IDLE, GAP: begin
                if (found) begin
                    state_nx    = GRANT;
                    grant_id_nx = pick;
                    slot_cnt_nx = '0;
                end else begin
                    state_nx    = IDLE;
                end
            end
            GRANT: begin
                if (!owner_elig || slot_cnt == SLOT_LAST) begin
                    state_nx  = GAP;
                    rr_ptr_nx = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
                end else begin
                    slot_cnt_nx = slot_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            slot_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant_id <= grant_id_nx;
            rr_ptr   <= rr_ptr_nx;
            slot_cnt <= slot_cnt_nx;
        end
    end

    // Plot bus holds its last pixel when nothing is accepted
    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            VGA_X       <= '0;
            VGA_Y       <= '0;
            VGA_COLOR   <= '0;
            plot_enable <= 1'b0;
        end else begin
            plot_enable <= accept;
            if (accept) begin
                VGA_X     <= sel_x;
                VGA_Y     <= sel_y;
                VGA_COLOR <= sel_c;
            end
        end
    end
endmodule

// File: tb/tb_paint_arbiter_rr.sv
// tb/tb_paint_arbiter_rr.sv - randomized and directed checks of paint_arbiter_rr against a behavioural model
module tb_paint_arbiter_rr;
    localparam int N    = 8;
    localparam int XW   = 9;
    localparam int YW   = 8;
    localparam int CW   = 3;
    localparam int SLOT = 4;

    logic            CLOCK_50 = 1'b0;
    logic            rstn     = 1'b0;
    logic [N-1:0]    src_req, src_mask, src_plot_en;
    logic [N*XW-1:0] src_x;
    logic [N*YW-1:0] src_y;
    logic [N*CW-1:0] src_color;
    logic [N-1:0]    src_gnt;
    logic [2:0]      grant_id;
    logic            busy;
    logic [XW-1:0]   VGA_X;
    logic [YW-1:0]   VGA_Y;
    logic [CW-1:0]   VGA_COLOR;
    logic            plot_enable;

    paint_arbiter_rr #(.NUM_SRC(N), .X_W(XW), .Y_W(YW), .C_W(CW), .SLOT_CYCLES(SLOT)) dut (
        .CLOCK_50(CLOCK_50), .rstn(rstn),
        .src_req(src_req), .src_mask(src_mask), .src_plot_en(src_plot_en),
        .src_x(src_x), .src_y(src_y), .src_color(src_color),
        .src_gnt(src_gnt), .grant_id(grant_id), .busy(busy),
        .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot_enable(plot_enable)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: owner index (-1 = nobody), cycles held, next search start, last plotted pixel
    int m_owner, m_last, m_ptr, m_held, m_x, m_y, m_c;
    bit m_pe;

    function automatic bit elig(int i);
        return src_req[i] && !src_mask[i];
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0;
        m_x = 0; m_y = 0; m_c = 0; m_pe = 0;
    endtask

    task automatic model_step();
        bit done;
        m_pe = (m_owner >= 0) && elig(m_owner) && src_plot_en[m_owner];
        if (m_pe) begin
            m_x = int'(src_x[m_owner*XW +: XW]);
            m_y = int'(src_y[m_owner*YW +: YW]);
            m_c = int'(src_color[m_owner*CW +: CW]);
        end
        if (m_owner >= 0) begin
            m_held++;
            if (!elig(m_owner) || m_held == SLOT) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            done = 0;
            for (int k = 0; k < N; k++) begin
                if (!done && elig((m_ptr + k) % N)) begin
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_held  = 0;
                    done    = 1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".gnt"}, 32'(src_gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_val({tag, ".id"}, 32'(grant_id), 32'(m_last));
        check_val({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        check_val({tag, ".pe"}, 32'(plot_enable), 32'(m_pe));
        check_val({tag, ".x"}, 32'(VGA_X), 32'(m_x));
        check_val({tag, ".y"}, 32'(VGA_Y), 32'(m_y));
        check_val({tag, ".c"}, 32'(VGA_COLOR), 32'(m_c));
    endtask

    task automatic cycle(input string tag);
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        check_outputs(tag);
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge
    task automatic do_reset(input string tag);
        @(negedge CLOCK_50);
        #2 rstn = 1'b0;
        #1 model_reset();
        check_outputs(tag);
        @(negedge CLOCK_50);
        rstn = 1'b1;
    endtask

    task automatic clear_inputs();
        src_req = '0; src_mask = '0; src_plot_en = '0;
        src_x = '0; src_y = '0; src_color = '0;
    endtask

    logic [9:0] pe_pat;
    int         order_q[$];
    int         exp_order[6] = '{0, 2, 5, 0, 2, 5};
    int         pix;
    bit         prev_busy;
    int         sel;

    initial begin
        clear_inputs();
        model_reset();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check_outputs("reset");
        rstn = 1'b1;

        // Single source: 4 pixels, one gap, 4 more
        src_req = 8'h01; src_plot_en = 8'h01;
        src_x[0 +: XW] = 9'd10; src_y[0 +: YW] = 8'd20; src_color[0 +: CW] = 3'b001;
        pe_pat = 10'b1111011110;
        for (int e = 0; e < 10; e++) begin
            cycle("single");
            check_val("single.pe_pattern", 32'(plot_enable), 32'(pe_pat[e]));
        end
        check_val("single.x", 32'(VGA_X), 32'd10);
        check_val("single.y", 32'(VGA_Y), 32'd20);

        // Round robin among 0, 2, 5
        do_reset("rst_rr");
        clear_inputs();
        src_req = 8'h25; src_plot_en = 8'h25;
        prev_busy = 0;
        for (int e = 0; e < 30; e++) begin
            cycle("rr");
            if (busy && !prev_busy) order_q.push_back(int'(grant_id));
            prev_busy = busy;
        end
        check_val("rr.count", 32'(order_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < order_q.size(); k++)
            check_val("rr.order", 32'(order_q[k]), 32'(exp_order[k]));

        // Early release: source 3 drops after 2 cycles, source 1 wins via wrap
        do_reset("rst_early");
        clear_inputs();
        src_req = 8'h08; src_plot_en = 8'h0A;
        src_x[3*XW +: XW] = 9'd300;
        cycle("early");
        pix = 0;
        for (int e = 0; e < 3; e++) begin
            if (e == 2) src_req = 8'h02;
            cycle("early");
            if (plot_enable) pix++;
        end
        check_val("early.gap", 32'(busy), 32'd0);
        check_val("early.pixels", 32'(pix), 32'd2);
        cycle("early");
        check_val("early.next_owner", 32'(grant_id), 32'd1);

        // Masked owner released, source 7 granted next
        do_reset("rst_mask");
        clear_inputs();
        src_req = 8'h10;
        cycle("mask");
        check_val("mask.owner4", 32'(grant_id), 32'd4);
        src_mask = 8'h10; src_req = 8'h90;
        cycle("mask");
        check_val("mask.gap", 32'(src_gnt), 32'd0);
        cycle("mask");
        check_val("mask.owner7", 32'(src_gnt), 32'h80);
        for (int e = 0; e < 12; e++) begin
            cycle("mask");
            check_val("mask.never4", 32'(src_gnt[4]), 32'd0);
        end

        // plot_en toggling: output follows one cycle later, X holds
        do_reset("rst_toggle");
        clear_inputs();
        src_req = 8'h01;
        cycle("toggle");
        for (int e = 0; e < 4; e++) begin
            src_plot_en[0] = (e % 2 == 0);
            src_x[0 +: XW] = 9'(e + 1);
            cycle("toggle");
            check_val("toggle.pe", 32'(plot_enable), 32'(e % 2 == 0));
            check_val("toggle.x", 32'(VGA_X), (e < 2) ? 32'd1 : 32'd3);
        end

        // Reset mid-grant, then 0 beats 6
        do_reset("rst_mid");
        clear_inputs();
        src_req = 8'h01; src_plot_en = 8'h01; src_x[0 +: XW] = 9'd55;
        cycle("mid");
        cycle("mid");
        #2 rstn = 1'b0;
        #1 model_reset();
        check_outputs("mid_async");
        check_val("mid.pe_async", 32'(plot_enable), 32'd0);
        @(negedge CLOCK_50);
        check_outputs("mid_held");
        src_req = 8'h41;
        rstn = 1'b1;
        cycle("mid");
        check_val("mid.winner", 32'(src_gnt), 32'h01);

        // Randomized traffic
        do_reset("rst_rand");
        clear_inputs();
        src_req = 8'($urandom);
        for (int e = 0; e < 600; e++) begin
            if ($urandom_range(0, 3) == 0) begin
                sel = int'($urandom_range(0, N - 1));
                src_req[sel] = ~src_req[sel];
            end
            if ($urandom_range(0, 15) == 0) begin
                sel = int'($urandom_range(0, N - 1));
                src_mask[sel] = ~src_mask[sel];
            end
            src_plot_en = 8'($urandom);
            src_x       = {$urandom, $urandom, $urandom};
            src_y       = {$urandom, $urandom};
            src_color   = 24'($urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
